// File: rtl/scarv_uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: frame width, default bit
// timing and the receiver state encoding.
package scarv_uart_pkg;

   localparam int UART_DATA_BITS     = 8;
   localparam int DEFAULT_BIT_CYCLES = 434;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with extra-MSB pointers; a simultaneous pop frees the
// slot a push into a full FIFO needs, so that push is still accepted.
module sync_byte_fifo
   import scarv_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          sys_clk,
   input  logic                          sys_reset,
   input  logic                          push,
   input  logic [UART_DATA_BITS-1:0]     data_in,
   output logic                          full,
   input  logic                          pop,
   output logic [UART_DATA_BITS-1:0]     data_out,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]               wr_ptr_q, wr_ptr_d;
   logic [AW:0]               rd_ptr_q, rd_ptr_d;
   logic                      do_push;
   logic                      do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign level    = wr_ptr_q - rd_ptr_q;
   assign data_out = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: data_out is masked to zero while empty.
   always_ff @(posedge sys_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_in;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling FSM and error pulses,
// feeding recovered bytes into a valid/ready byte FIFO.
module uart_rx_fifo
   import scarv_uart_pkg::*;
#(
   parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          sys_clk,
   input  logic                          sys_reset,
   input  logic                          uart_rxd,
   output logic                          rx_valid,
   output logic [UART_DATA_BITS-1:0]     rx_data,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          frame_err,
   output logic                          overrun
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);

   rx_state_e                 state_q, state_d;
   logic [CW-1:0]             cyc_q, cyc_d;
   logic [BW-1:0]             bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      rxd_meta_q, rxd_s_q;
   logic                      frame_err_q, frame_err_d;
   logic                      overrun_q, overrun_d;
   logic                      push;
   logic                      fifo_full;
   logic                      fifo_empty;

   assign rx_valid  = !fifo_empty;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign overrun_d = push && fifo_full && !(rx_ready && rx_valid);

   // Start is confirmed at half a bit, after which every sample lands mid-bit.
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxd_s_q) begin
               state_d = START;
               cyc_d   = '0;
            end
         end
         START: begin
            if (cyc_q == HALF_LAST) begin
               cyc_d   = '0;
               bit_d   = '0;
               state_d = rxd_s_q ? IDLE : DATA;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         DATA: begin
            if (cyc_q == BIT_LAST) begin
               cyc_d   = '0;
               shift_d = {rxd_s_q, shift_q[UART_DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         STOP: begin
            if (cyc_q == BIT_LAST) begin
               cyc_d = '0;
               if (rxd_s_q) begin
                  push    = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         BREAK: begin
            if (rxd_s_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         rxd_meta_q  <= 1'b1;
         rxd_s_q     <= 1'b1;
         state_q     <= IDLE;
         cyc_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rxd_meta_q  <= uart_rxd;
         rxd_s_q     <= rxd_meta_q;
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   sync_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_reset (sys_reset),
      .push      (push),
      .data_in   (shift_q),
      .full      (fifo_full),
      .pop       (rx_ready),
      .data_out  (rx_data),
      .empty     (fifo_empty),
      .level     (rx_level)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes are queued when their frame is sent
// and checked by a monitor whenever the DUT hands one over.
module tb_uart_rx_fifo;

   localparam int BIT_CYCLES   = 434;
   localparam int FIFO_DEPTH   = 8;
   localparam int LW           = $clog2(FIFO_DEPTH);
   // Two synchroniser flops, one IDLE edge, half a start bit, then 9 full bits.
   localparam int PUSH_LATENCY = 3 + BIT_CYCLES / 2 + 9 * BIT_CYCLES;

   logic          sysClk = 1'b0;
   logic          sysReset;
   logic          uartRxd;
   logic          rxValid;
   logic [7:0]    rxData;
   logic          rxReady;
   logic [LW:0]   rxLevel;
   logic          frameErr;
   logic          overrun;

   int            assertCnt   = 0;
   int            failCnt     = 0;
   int            popCnt      = 0;
   int            frameErrCnt = 0;
   int            overrunCnt  = 0;
   longint        cycleCnt    = 0;
   logic [7:0]    expQ [$];
   logic          holdArmed   = 1'b0;
   logic [7:0]    holdData    = '0;

   uart_rx_fifo #(
      .BIT_CYCLES (BIT_CYCLES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .sys_clk   (sysClk),
      .sys_reset (sysReset),
      .uart_rxd  (uartRxd),
      .rx_valid  (rxValid),
      .rx_data   (rxData),
      .rx_ready  (rxReady),
      .rx_level  (rxLevel),
      .frame_err (frameErr),
      .overrun   (overrun)
   );

   always #10 sysClk = ~sysClk;

   always @(posedge sysClk) cycleCnt <= cycleCnt + 1;

   // Scoreboard monitor: every accepted byte must match the oldest queued one.
   always @(negedge sysClk) begin
      logic [7:0] expByte;
      if (!sysReset) begin
         if (rxValid && rxReady) begin
            assertCnt++;
            popCnt++;
            if (expQ.size() == 0) begin
               failCnt++;
               $display("[TB] FAIL pop_unexpected: got 0x%02h, required no byte", rxData);
            end else begin
               expByte = expQ.pop_front();
               if (rxData !== expByte) begin
                  failCnt++;
                  $display("[TB] FAIL pop_data: got 0x%02h, required 0x%02h", rxData, expByte);
               end
            end
         end
         if (holdArmed && rxValid) begin
            assertCnt++;
            if (rxData !== holdData) begin
               failCnt++;
               $display("[TB] FAIL hold_data: got 0x%02h, required 0x%02h", rxData, holdData);
            end
         end
         holdArmed = rxValid && !rxReady;
         holdData  = rxData;
         if (frameErr === 1'b1) frameErrCnt++;
         if (overrun === 1'b1) overrunCnt++;
      end else begin
         holdArmed = 1'b0;
      end
   end

   task automatic idleCycles(input int n);
      repeat (n) @(posedge sysClk);
      #1;
   endtask

   task automatic sendFrame(input logic [7:0] value, input logic stopBit);
      uartRxd = 1'b0;
      idleCycles(BIT_CYCLES);
      for (int i = 0; i < 8; i++) begin
         uartRxd = value[i];
         idleCycles(BIT_CYCLES);
      end
      uartRxd = stopBit;
      idleCycles(BIT_CYCLES);
   endtask

   task automatic test_reset();
      sysReset = 1'b1;
      uartRxd  = 1'b1;
      rxReady  = 1'b0;
      idleCycles(5);
      assertCnt++;
      if ({rxValid, rxData, rxLevel, frameErr, overrun} !== '0) begin
         failCnt++;
         $display("[TB] FAIL reset_outputs: got valid=%b data=0x%02h level=%0d ferr=%b ovr=%b, required all 0",
                  rxValid, rxData, rxLevel, frameErr, overrun);
      end
      sysReset = 1'b0;
      idleCycles(5);
   endtask

   task automatic test_basic();
      logic [7:0] bytes [2] = '{8'h55, 8'hA3};
      int ferr0 = frameErrCnt;
      int ovr0  = overrunCnt;
      int pop0  = popCnt;
      rxReady = 1'b1;
      foreach (bytes[k]) begin
         longint startCycle = cycleCnt;
         longint latency    = -1;
         expQ.push_back(bytes[k]);
         fork
            sendFrame(bytes[k], 1'b1);
            begin
               for (int i = 0; i < PUSH_LATENCY + 50 && latency < 0; i++) begin
                  @(negedge sysClk);
                  if (rxValid) latency = cycleCnt - startCycle;
               end
            end
         join
         assertCnt++;
         if (latency != PUSH_LATENCY) begin
            failCnt++;
            $display("[TB] FAIL valid_latency: got %0d cycles, required %0d", latency, PUSH_LATENCY);
         end
         idleCycles(20);
      end
      assertCnt++;
      if (popCnt - pop0 != 2 || frameErrCnt != ferr0 || overrunCnt != ovr0) begin
         failCnt++;
         $display("[TB] FAIL basic_counts: got pops=%0d ferr=%0d ovr=%0d, required 2 0 0",
                  popCnt - pop0, frameErrCnt - ferr0, overrunCnt - ovr0);
      end
   endtask

   task automatic test_glitch();
      int ferr0 = frameErrCnt;
      int pop0  = popCnt;
      uartRxd = 1'b0;
      idleCycles(100);
      uartRxd = 1'b1;
      idleCycles(400);
      assertCnt++;
      if (popCnt != pop0 || frameErrCnt != ferr0 || rxLevel !== '0) begin
         failCnt++;
         $display("[TB] FAIL glitch_ignored: got pops=%0d ferr=%0d level=%0d, required 0 0 0",
                  popCnt - pop0, frameErrCnt - ferr0, rxLevel);
      end
      expQ.push_back(8'h3C);
      sendFrame(8'h3C, 1'b1);
      idleCycles(20);
      assertCnt++;
      if (popCnt - pop0 != 1 || expQ.size() != 0) begin
         failCnt++;
         $display("[TB] FAIL glitch_next_frame: got pops=%0d pending=%0d, required 1 0",
                  popCnt - pop0, expQ.size());
      end
   endtask

   task automatic test_frame_error();
      int ferr0 = frameErrCnt;
      int pop0  = popCnt;
      sendFrame(8'hFF, 1'b0);
      idleCycles(2000);
      uartRxd = 1'b1;
      idleCycles(20);
      assertCnt++;
      if (frameErrCnt - ferr0 != 1) begin
         failCnt++;
         $display("[TB] FAIL frame_err_count: got %0d pulses, required 1", frameErrCnt - ferr0);
      end
      assertCnt++;
      if (rxLevel !== '0 || popCnt != pop0 || rxValid !== 1'b0) begin
         failCnt++;
         $display("[TB] FAIL frame_err_dropped: got level=%0d pops=%0d valid=%b, required 0 0 0",
                  rxLevel, popCnt - pop0, rxValid);
      end
   endtask

   task automatic test_overrun();
      int ovr0  = overrunCnt;
      int ferr0 = frameErrCnt;
      rxReady = 1'b0;
      for (int v = 0; v < 9; v++) begin
         if (v < 8) expQ.push_back(8'(v));
         sendFrame(8'(v), 1'b1);
         idleCycles(10);
         if (v == 7) begin
            assertCnt++;
            if (rxLevel !== (LW+1)'(8) || overrunCnt != ovr0) begin
               failCnt++;
               $display("[TB] FAIL fill_level: got level=%0d ovr=%0d, required 8 0",
                        rxLevel, overrunCnt - ovr0);
            end
         end
      end
      assertCnt++;
      if (overrunCnt - ovr0 != 1 || frameErrCnt != ferr0) begin
         failCnt++;
         $display("[TB] FAIL overrun_pulse: got ovr=%0d ferr=%0d, required 1 0",
                  overrunCnt - ovr0, frameErrCnt - ferr0);
      end
      assertCnt++;
      if (rxLevel !== (LW+1)'(8) || rxValid !== 1'b1 || rxData !== 8'h00) begin
         failCnt++;
         $display("[TB] FAIL overrun_contents: got level=%0d valid=%b head=0x%02h, required 8 1 0x00",
                  rxLevel, rxValid, rxData);
      end
   endtask

   task automatic test_full_push_pop();
      int ovr0 = overrunCnt;
      int pop0 = popCnt;
      expQ.push_back(8'h08);
      fork
         sendFrame(8'h08, 1'b1);
         begin
            repeat (PUSH_LATENCY - 1) @(posedge sysClk);
            #1 rxReady = 1'b1;
            @(posedge sysClk);
            #1 rxReady = 1'b0;
            @(negedge sysClk);
            assertCnt++;
            if (rxLevel !== (LW+1)'(8) || overrun !== 1'b0) begin
               failCnt++;
               $display("[TB] FAIL push_pop_full: got level=%0d ovr=%b, required 8 0", rxLevel, overrun);
            end
         end
      join
      idleCycles(10);
      assertCnt++;
      if (overrunCnt != ovr0 || popCnt - pop0 != 1) begin
         failCnt++;
         $display("[TB] FAIL push_pop_counts: got ovr=%0d pops=%0d, required 0 1",
                  overrunCnt - ovr0, popCnt - pop0);
      end
      rxReady = 1'b1;
      idleCycles(4);
      rxReady = 1'b0;
      idleCycles(2);
      assertCnt++;
      if (rxLevel !== (LW+1)'(4) || rxValid !== 1'b1 || rxData !== 8'h05 || expQ.size() != 4) begin
         failCnt++;
         $display("[TB] FAIL partial_drain: got level=%0d valid=%b head=0x%02h pending=%0d, required 4 1 0x05 4",
                  rxLevel, rxValid, rxData, expQ.size());
      end
   endtask

   task automatic test_reset_midframe();
      int pop0  = popCnt;
      int ferr0 = frameErrCnt;
      fork
         sendFrame(8'hF8, 1'b1);
         begin
            repeat (4 * BIT_CYCLES + 200) @(posedge sysClk);
            #1 sysReset = 1'b1;
            expQ.delete();
            repeat (3) @(posedge sysClk);
            #1 sysReset = 1'b0;
            @(negedge sysClk);
            assertCnt++;
            if (rxLevel !== '0 || rxValid !== 1'b0 || rxData !== 8'h00) begin
               failCnt++;
               $display("[TB] FAIL reset_flush: got level=%0d valid=%b data=0x%02h, required 0 0 0x00",
                        rxLevel, rxValid, rxData);
            end
         end
      join
      idleCycles(20);
      rxReady = 1'b1;
      expQ.push_back(8'hC3);
      sendFrame(8'hC3, 1'b1);
      idleCycles(20);
      assertCnt++;
      if (popCnt - pop0 != 1 || expQ.size() != 0 || frameErrCnt != ferr0) begin
         failCnt++;
         $display("[TB] FAIL reset_next_frame: got pops=%0d pending=%0d ferr=%0d, required 1 0 0",
                  popCnt - pop0, expQ.size(), frameErrCnt - ferr0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_full_push_pop();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
